// File: rtl/mem_monitor.sv
// Read-only memory window scanner: reads via a second RAM port and shows each word on four 7-seg digits.
// Word appears RD_LAT+1 cycles after rd_en; optional MON_SKIP_ZERO_EN skips zero words in auto scan.
module mem_monitor #(
   parameter int BW     = 16,
   parameter int AW     = 9,
   parameter int HOLD   = 1000000,
   parameter int RD_LAT = 1
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_en,
   input  logic          i_auto,
   input  logic          i_step,
   input  logic [AW-1:0] i_start_addr,
   input  logic [AW-1:0] i_end_addr,
   output logic [AW-1:0] o_rd_addr,
   output logic          o_rd_en,
   input  logic [BW-1:0] i_rd_data,
   output logic [AW-1:0] o_cur_addr,
   output logic [BW-1:0] o_word,
   output logic          o_valid,
   output logic [6:0]    o_hex0,
   output logic [6:0]    o_hex1,
   output logic [6:0]    o_hex2,
   output logic [6:0]    o_hex3
);

   localparam int HW = $clog2(HOLD);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_SHOW} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_cur_addr;
   logic [AW-1:0] r_rd_addr;
   logic [BW-1:0] r_word;
   logic          r_valid;
   logic [6:0]    r_hex0, r_hex1, r_hex2, r_hex3;
   logic [HW-1:0] r_hold_cnt;
   logic [1:0]    r_wait_cnt;
   logic [AW-1:0] w_adv_addr;
   logic          w_lat_done;
   logic          w_expire;
   logic          w_skip;
   logic          w_advance;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
      endcase
   endfunction

   // Window bounds are sampled live, so edits land on the next advance.
   assign w_adv_addr = (r_cur_addr == i_end_addr) ? i_start_addr : r_cur_addr + AW'(1);
   assign w_lat_done = (r_wait_cnt == 2'(RD_LAT - 1));
   assign w_expire   = i_auto && (r_hold_cnt == HW'(HOLD - 1));

`ifdef MON_SKIP_ZERO_EN
   logic [AW:0] r_skip_cnt;
   logic [AW:0] w_win_len;

   // Once a full window of zeros has been skipped, the next zero is held so the display never free-runs.
   assign w_win_len = {1'b0, i_end_addr - i_start_addr} + (AW+1)'(1);
   assign w_skip    = i_auto && (r_word == '0) && (r_skip_cnt < w_win_len);

   always_ff @(posedge i_clk) begin
      if (i_rstn) begin
         r_skip_cnt <= '0;
      end else if (i_en && r_state == S_WAIT && w_lat_done && i_rd_data != '0) begin
         r_skip_cnt <= '0;
      end else if (w_advance) begin
         r_skip_cnt <= w_skip ? r_skip_cnt + (AW+1)'(1) : '0;
      end
   end
`else
   assign w_skip = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_advance = 1'b0;
      case (r_state)
         S_IDLE:  if (i_en) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_lat_done) w_next = S_SHOW;
         S_SHOW: begin
            if (i_step || w_expire || w_skip) begin
               w_advance = 1'b1;
               w_next    = S_ISSUE;
            end
         end
         default: w_next = S_IDLE;
      endcase
      if (!i_en) begin
         w_next    = S_IDLE;
         w_advance = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rstn) begin
         r_state    <= S_IDLE;
         r_cur_addr <= '0;
         r_rd_addr  <= '0;
         r_word     <= '0;
         r_valid    <= 1'b0;
         r_hex0     <= 7'h7F;
         r_hex1     <= 7'h7F;
         r_hex2     <= 7'h7F;
         r_hex3     <= 7'h7F;
         r_hold_cnt <= '0;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (!i_en) begin
            r_valid <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cur_addr <= i_start_addr;
                  r_rd_addr  <= i_start_addr;
               end
               S_ISSUE: r_wait_cnt <= '0;
               S_WAIT: begin
                  if (w_lat_done) begin
                     r_word     <= i_rd_data;
                     r_hex0     <= seg7(i_rd_data[3:0]);
                     r_hex1     <= seg7(i_rd_data[7:4]);
                     r_hex2     <= seg7(i_rd_data[11:8]);
                     r_hex3     <= seg7(i_rd_data[15:12]);
                     r_valid    <= 1'b1;
                     r_hold_cnt <= '0;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 2'd1;
                  end
               end
               S_SHOW: begin
                  if (w_advance) begin
                     r_cur_addr <= w_adv_addr;
                     r_rd_addr  <= w_adv_addr;
                     r_valid    <= 1'b0;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + HW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_rd_en    = (r_state == S_ISSUE);
   assign o_rd_addr  = r_rd_addr;
   assign o_cur_addr = r_cur_addr;
   assign o_word     = r_word;
   assign o_valid    = r_valid;
   assign o_hex0     = r_hex0;
   assign o_hex1     = r_hex1;
   assign o_hex2     = r_hex2;
   assign o_hex3     = r_hex3;

endmodule

// File: tb/tb_mem_monitor.sv
// Directed bench for mem_monitor with a behavioural RAM and an expected-capture queue.
module tb_mem_monitor;

   logic        clk, rstn, en, auto_m, step;
   logic [8:0]  start_a, end_a, rd_addr, cur_addr;
   logic        rd_en, valid;
   logic [15:0] rd_q, word;
   logic [6:0]  hex0, hex1, hex2, hex3;

   logic [15:0] mem [512];

   typedef struct {
      logic [8:0]  a;
      logic [15:0] w;
   } exp_t;
   exp_t q[$];

   int n_cmp = 0;
   int n_err = 0;
   int rden_cnt = 0;
   logic pv = 1'b0;
   logic pr = 1'b0;

   mem_monitor #(.BW(16), .AW(9), .HOLD(4), .RD_LAT(1)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_auto(auto_m), .i_step(step),
      .i_start_addr(start_a), .i_end_addr(end_a),
      .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_data(rd_q),
      .o_cur_addr(cur_addr), .o_word(word), .o_valid(valid),
      .o_hex0(hex0), .o_hex1(hex1), .o_hex2(hex2), .o_hex3(hex3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) rd_q <= mem[rd_addr];

   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every fresh capture must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rstn) begin
         if (rd_en) begin
            rden_cnt++;
            chk("rden_b2b", {31'd0, pr}, 0);
         end
         if (valid && !pv) begin
            chk("cap_expected", {31'd0, q.size() != 0}, 1);
            if (q.size() != 0) begin
               exp_t e;
               e = q.pop_front();
               chk("cap_addr", {23'd0, cur_addr}, {23'd0, e.a});
               chk("cap_word", {16'd0, word}, {16'd0, e.w});
               chk("cap_hex0", {25'd0, hex0}, {25'd0, seg(e.w[3:0])});
               chk("cap_hex1", {25'd0, hex1}, {25'd0, seg(e.w[7:4])});
               chk("cap_hex2", {25'd0, hex2}, {25'd0, seg(e.w[11:8])});
               chk("cap_hex3", {25'd0, hex3}, {25'd0, seg(e.w[15:12])});
            end
         end
      end
      pv <= valid;
      pr <= rd_en;
   end

   task automatic push(input logic [8:0] a);
      exp_t e;
      e.a = a;
      e.w = mem[a];
      q.push_back(e);
   endtask

   task automatic wait_rise(input string tag);
      int n = 0;
      while (valid === 1'b1 && n < 50) begin cyc(1); n++; end
      while (valid !== 1'b1 && n < 50) begin cyc(1); n++; end
      chk({tag, "_timeout"}, {31'd0, n < 50}, 1);
   endtask

   task automatic hold_len(output int n);
      n = 0;
      while (valid === 1'b1 && n < 50) begin n++; cyc(1); end
   endtask

   task automatic do_step(input logic [8:0] a, input bit pulse_in_wait);
      int n0;
      push(a);
      n0 = rden_cnt;
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(1);
      if (pulse_in_wait) begin
         step = 1'b1;
         cyc(1);
         step = 1'b0;
      end
      cyc(5);
      chk("man_cur", {23'd0, cur_addr}, {23'd0, a});
      chk("man_one_read", rden_cnt - n0, 1);
      chk("man_valid", {31'd0, valid}, 1);
   endtask

   initial begin
      int n, n0;
      for (int i = 0; i < 512; i++) mem[i] = 16'(i * 37 + 16'h1111);
      mem[5] = 16'h1A2F;
      rstn = 1'b1; en = 1'b1; auto_m = 1'b0; step = 1'b0;
      start_a = 9'd5; end_a = 9'd5;

      // Reset with en high
      cyc(2);
      chk("rst_hex0", {25'd0, hex0}, 32'h7F);
      chk("rst_hex1", {25'd0, hex1}, 32'h7F);
      chk("rst_hex2", {25'd0, hex2}, 32'h7F);
      chk("rst_hex3", {25'd0, hex3}, 32'h7F);
      chk("rst_valid", {31'd0, valid}, 0);
      chk("rst_rden", {31'd0, rd_en}, 0);
      chk("rst_word", {16'd0, word}, 0);
      chk("rst_cur", {23'd0, cur_addr}, 0);
      chk("rst_rdaddr", {23'd0, rd_addr}, 0);

      // Latency and decode
      push(9'd5);
      rstn = 1'b0;
      cyc(1);
      chk("rel_rden", {31'd0, rd_en}, 1);
      chk("rel_rdaddr", {23'd0, rd_addr}, 5);
      cyc(1);
      chk("lat_not_yet", {31'd0, valid}, 0);
      cyc(1);
      chk("lat_word", {16'd0, word}, 32'h1A2F);
      chk("lat_valid", {31'd0, valid}, 1);
      chk("lat_hex3", {25'd0, hex3}, 32'h79);
      chk("lat_hex2", {25'd0, hex2}, 32'h08);
      chk("lat_hex1", {25'd0, hex1}, 32'h24);
      chk("lat_hex0", {25'd0, hex0}, 32'h0E);
      chk("lat_cur", {23'd0, cur_addr}, 5);
      cyc(3);
      chk("man_idle_cur", {23'd0, cur_addr}, 5);
      chk("man_idle_valid", {31'd0, valid}, 1);

      // Disable in SHOW, then manual stepping with wrap
      start_a = 9'd3; end_a = 9'd5; en = 1'b0;
      cyc(1);
      chk("dis_valid", {31'd0, valid}, 0);
      chk("dis_word", {16'd0, word}, 32'h1A2F);
      chk("dis_hex3", {25'd0, hex3}, 32'h79);
      chk("dis_cur", {23'd0, cur_addr}, 5);
      cyc(2);
      chk("dis_rden", {31'd0, rd_en}, 0);
      push(9'd3);
      en = 1'b1;
      cyc(4);
      chk("reen_cur", {23'd0, cur_addr}, 3);
      do_step(9'd4, 1'b1);
      do_step(9'd5, 1'b0);
      do_step(9'd3, 1'b0);
      chk("man_drained", q.size(), 0);

      // Auto scan across the top of the address space
      en = 1'b0;
      cyc(1);
      auto_m = 1'b1; start_a = 9'd510; end_a = 9'd1;
      push(9'd510); push(9'd511); push(9'd0); push(9'd1); push(9'd510);
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_rise("auto");
         hold_len(n);
         chk("auto_hold", n, 4);
      end

      // Step coinciding with timer expiry
      push(9'd511);
      wait_rise("coin");
      cyc(3);
      n0 = rden_cnt;
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      push(9'd0);
      wait_rise("coin_next");
      chk("coin_one_read", rden_cnt - n0, 1);
      chk("coin_cur", {23'd0, cur_addr}, 0);
      hold_len(n);
      chk("coin_hold", n, 4);

      // Reset while a read is in flight
      chk("mid_rden", {31'd0, rd_en}, 1);
      cyc(1);
      rstn = 1'b1;
      cyc(1);
      chk("mid_word", {16'd0, word}, 0);
      chk("mid_valid", {31'd0, valid}, 0);
      chk("mid_hex0", {25'd0, hex0}, 32'h7F);
      chk("mid_cur", {23'd0, cur_addr}, 0);
      en = 1'b0;
      cyc(1);
      rstn = 1'b0;
      cyc(3);
      chk("mid_no_cap", {31'd0, valid}, 0);
      chk("mid_drained", q.size(), 0);
      push(9'd510);
      en = 1'b1;
      wait_rise("restart");
      chk("restart_cur", {23'd0, cur_addr}, 510);
      en = 1'b0;
      cyc(2);
      chk("final_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
